// File: rtl/mem_responder.sv
// Fixed-latency word-addressed memory responder arbitrating between the CPU's
// instruction-fetch and data ports; each access ends with a one-cycle valid pulse.
module mem_responder #(
  parameter int LATENCY = 4,
  parameter int MEM_AW  = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic [15:0] i_rdata,
  output logic        i_valid,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_valid,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t              state;
  logic [3:0]          cnt;
  logic                ptr_d;
  logic                cap_wr;
  logic [MEM_AW-1:0]   cap_idx;
  logic [15:0]         cap_wdata;
  logic [15:0]         mem [2**MEM_AW];

  logic                grant_d, grant_i;
  logic                fin, fin_d, fin_wr;
  logic [MEM_AW-1:0]   fin_idx;
  logic [15:0]         fin_wdata;

  // Byte bits and bits above the array width are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr, d_addr};

  assign grant_d = d_req && (!i_req || ptr_d);
  assign grant_i = i_req && !grant_d;
  assign busy    = (state != IDLE);

  // fin marks the edge that performs the access and enters RESP. The counter
  // reaches 0 on that edge, so the valid lands LATENCY cycles after acceptance.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    fin       = 1'b0;
    fin_d     = 1'b0;
    fin_wr    = 1'b0;
    fin_idx   = cap_idx;
    fin_wdata = cap_wdata;
    case (state)
      IDLE: begin
        if (LATENCY == 1 && (grant_d || grant_i)) begin
          fin       = 1'b1;
          fin_d     = grant_d;
          fin_wr    = grant_d && d_wr;
          fin_idx   = grant_d ? d_addr[MEM_AW:1] : i_addr[MEM_AW:1];
          fin_wdata = d_wdata;
        end
      end
      BUSY_I: fin = (cnt == 4'd1);
      BUSY_D: begin
        fin    = (cnt == 4'd1);
        fin_d  = 1'b1;
        fin_wr = cap_wr;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr_d     <= 1'b1;
      cap_wr    <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
      i_valid   <= 1'b0;
      d_valid   <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d || grant_i) begin
            if (i_req && d_req) ptr_d <= !grant_d;
            cnt       <= CNT_LOAD;
            cap_wr    <= grant_d && d_wr;
            cap_idx   <= grant_d ? d_addr[MEM_AW:1] : i_addr[MEM_AW:1];
            cap_wdata <= d_wdata;
            state     <= fin ? RESP : (grant_d ? BUSY_D : BUSY_I);
          end
        end
        BUSY_I, BUSY_D: begin
          cnt <= cnt - 4'd1;
          if (fin) state <= RESP;
        end
        RESP: begin
          i_valid <= 1'b0;
          d_valid <= 1'b0;
          i_rdata <= '0;
          d_rdata <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (fin) begin
        i_valid <= !fin_d;
        d_valid <= fin_d;
        if (fin_d) d_rdata <= fin_wr ? 16'h0000 : mem[fin_idx];
        else       i_rdata <= mem[fin_idx];
      end
    end
  end

  // NOTE: the array is not reset; it is storage, not control state.
  always_ff @(posedge clk) begin
    if (rst_n && fin && fin_d && fin_wr) mem[fin_idx] <= fin_wdata;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus pushes expected responses,
// a negedge monitor pops and compares port, data and arrival cycle.
module tb_mem_responder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = '0;
  logic [15:0] i_rdata;
  logic        i_valid;
  logic        d_req = 1'b0;
  logic        d_wr = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic [15:0] d_rdata;
  logic        d_valid;
  logic        busy;

  mem_responder #(.LATENCY(LAT), .MEM_AW(13)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_d;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: any valid must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (i_valid || d_valid)) begin
      exp_t e;
      check("one_valid", 32'(i_valid & d_valid), 32'd0);
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("port", 32'(d_valid), 32'(e.is_d));
        check("rdata", 32'(d_valid ? d_rdata : i_rdata), 32'(e.data));
        check("other_rdata_zero", 32'(d_valid ? i_rdata : d_rdata), 32'd0);
        check("arrival_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic wait_valids(input int n);
    int seen = 0;
    for (int k = 0; k < 100 && seen < n; k++) begin
      @(negedge clk);
      if (i_valid || d_valid) seen++;
    end
    check("wait_valids", 32'(seen), 32'(n));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drop();
    i_req = 1'b0; d_req = 1'b0;
  endtask

  // Requests are left high after completion; callers drop() when done.
  task automatic issue_d(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] exp_data);
    d_req = 1'b1; d_wr = wr; d_addr = addr; d_wdata = wdata;
    sb.push_back('{is_d: 1'b1, data: (wr ? 16'h0 : exp_data), cyc: cyc + LAT});
    wait_valids(1);
  endtask

  task automatic issue_i(input logic [15:0] addr, input logic [15:0] exp_data);
    i_req = 1'b1; i_addr = addr;
    sb.push_back('{is_d: 1'b0, data: exp_data, cyc: cyc + LAT});
    wait_valids(1);
  endtask

  initial begin
    do_reset();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_i_valid", 32'(i_valid), 32'd0);
    check("rst_d_valid", 32'(d_valid), 32'd0);
    check("rst_i_rdata", 32'(i_rdata), 32'd0);
    check("rst_d_rdata", 32'(d_rdata), 32'd0);

    // Write then read, d_req held through RESP: accepted again in cycle 5.
    issue_d(1'b1, 16'h0010, 16'hBEEF, 16'h0);
    issue_d(1'b0, 16'h0010, 16'h0000, 16'hBEEF);
    drop();

    // Odd fetch address maps to the same word.
    issue_d(1'b1, 16'h0010, 16'h1234, 16'h0);
    drop();
    issue_i(16'h0011, 16'h1234);
    drop();

    // Address wrap-around and top-of-array word.
    issue_d(1'b1, 16'h0002, 16'hA5A5, 16'h0);
    issue_d(1'b0, 16'h4002, 16'h0000, 16'hA5A5);
    drop();
    issue_i(16'h4003, 16'hA5A5);
    drop();
    issue_d(1'b1, 16'h3FFE, 16'hC3C3, 16'h0);
    issue_d(1'b0, 16'hFFFE, 16'h0000, 16'hC3C3);
    drop();

    // Input changes after acceptance are ignored.
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0010;
    sb.push_back('{is_d: 1'b1, data: 16'h1234, cyc: cyc + LAT});
    @(posedge clk); #1 d_addr = 16'h0002; d_wr = 1'b1;
    wait_valids(1);
    drop();
    d_wr = 1'b0;

    // Reset mid-write abandons the write.
    issue_d(1'b1, 16'h0020, 16'h5555, 16'h0);
    drop();
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0020; d_wdata = 16'h7777;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0; drop();
    #1 check("midrst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_d_valid", 32'(d_valid), 32'd0);
    issue_d(1'b0, 16'h0020, 16'h0000, 16'h5555);
    drop();

    // Both requesting from reset: data, instr, data at cycles 4, 9, 14.
    do_reset();
    i_req = 1'b1; i_addr = 16'h0002;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0010;
    sb.push_back('{is_d: 1'b1, data: 16'h1234, cyc: cyc + 4});
    sb.push_back('{is_d: 1'b0, data: 16'hA5A5, cyc: cyc + 9});
    sb.push_back('{is_d: 1'b1, data: 16'h1234, cyc: cyc + 14});
    wait_valids(3);
    drop();

    repeat (8) @(posedge clk);
    #1 check("sb_drained", 32'(sb.size()), 32'd0);
    check("final_busy", 32'(busy), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
